button_conditioner: RTL and testbench

//  Conditions one raw push-button (minute set, hour set or reset) for the wall-clock core.

---
 rtl/button_pkg.sv | 21 ++
 rtl/sync_ff_chain.sv | 23 ++
 rtl/button_conditioner.sv | 121 ++++++++++++
 tb/tb_button_conditioner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } btn_state_t;

    // Counter width large enough for the biggest cycle count, plus one spare bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for one asynchronous input bit; reset clears every stage.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Raw button -> synchroniser -> debounce FSM -> single-cycle press pulse.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-auto-repeat pulses and the held flag.
module button_conditioner
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic CLK100MHZ,
    input  logic Reset,
    input  logic button_in,
    output logic pressed_pulse,
    output logic level,
    output logic held
);

    localparam int CW = cnt_width(SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            btn_s;
    btn_state_t      state;
    logic [CW-1:0]   cnt;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLK100MHZ),
        .rst (Reset),
        .d   (button_in),
        .q   (btn_s)
    );

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    logic [CW-1:0] rpt;
    // fast: first repeat already issued, so rpt now measures the shorter rate period
    logic          fast;
`else
    assign held = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pressed_pulse <= 1'b0;
            level         <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            held          <= 1'b0;
            rpt           <= '0;
            fast          <= 1'b0;
`endif
        end else begin
            pressed_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state         <= PRESSED;
                        level         <= 1'b1;
                        pressed_pulse <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                        rpt           <= '0;
                        fast          <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
                        rpt   <= '0;
                        fast  <= 1'b0;
                    end else if (rpt == (fast ? RATE_LAST : DELAY_LAST)) begin
                        pressed_pulse <= 1'b1;
                        held          <= 1'b1;
                        fast          <= 1'b1;
                        rpt           <= '0;
                    end else begin
                        rpt <= rpt + 1'b1;
`endif
                    end
                end
                DB_RELEASE: begin
                    // A short low while held is bounce: go back and re-arm the repeat delay.
                    if (btn_s) begin
                        state <= PRESSED;
`ifdef BUTTON_AUTO_REPEAT_EN
                        rpt   <= '0;
                        fast  <= 1'b0;
`endif
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
                        held  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: run-length debounce model plus directed and random button stimulus.
module tb_button_conditioner;

    localparam int SYNC   = 2;
    localparam int DB     = 4;
    localparam int RDELAY = 20;
    localparam int RRATE  = 6;
    localparam int HMAX   = 8192;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic pulse;
    logic lvl;
    logic hld;

    always #5 clk = ~clk;

    button_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RDELAY),
        .REPEAT_RATE     (RRATE)
    ) dut (
        .CLK100MHZ     (clk),
        .Reset         (rst),
        .button_in     (btn),
        .pressed_pulse (pulse),
        .level         (lvl),
        .held          (hld)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ecount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Behavioural model: the FSM sees the input delayed by SYNC edges (zero across reset);
    // level flips after DB+1 consecutive samples that disagree with it; repeat pulses come
    // from counting consecutive edges spent settled in the pressed state.
    bit in_hist [HMAX];
    int last_rst = 0;
    bit m_level, m_held, m_pulse;
    int m_run, m_t;

    always @(posedge clk) begin
        int idx;
        bit s, settled;
        ecount++;
        if (ecount < HMAX) in_hist[ecount] = btn;
        if (rst) begin
            last_rst = ecount;
            m_level = 0; m_held = 0; m_pulse = 0; m_run = 0; m_t = 0;
        end else begin
            idx = ecount - SYNC;
            s = (idx > last_rst && idx < HMAX) ? in_hist[idx] : 1'b0;
            settled = m_level && (m_run == 0);
            m_pulse = 0;
            if (s != m_level) begin
                m_run++;
                m_t = 0;
                if (m_run == DB + 1) begin
                    m_level = s;
                    m_run = 0;
                    if (s) m_pulse = 1;
                    else   m_held = 0;
                end
            end else begin
                if (settled) begin
                    m_t++;
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (m_t == RDELAY || (m_t > RDELAY && (m_t - RDELAY) % RRATE == 0)) begin
                        m_pulse = 1;
                        m_held = 1;
                    end
`endif
                end else begin
                    m_t = 0;
                end
                m_run = 0;
            end
        end
    end

    int pulses[$];
    int falls[$];
    int first_held = -1;
    logic prev_lvl = 1'b0;

    always @(negedge clk) begin
        if (ecount > 0) begin
            check("pulse", pulse, m_pulse);
            check("level", lvl, m_level);
            check("held", hld, m_held);
            if (pulse === 1'b1) pulses.push_back(ecount);
            if (prev_lvl === 1'b1 && lvl === 1'b0) falls.push_back(ecount);
            if (hld === 1'b1 && first_held < 0) first_held = ecount;
            prev_lvl = lvl;
        end
    end

    task automatic hold(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            btn = v;
        end
    endtask

    task automatic start(output int p);
        @(negedge clk);
        btn = 1'b1;
        p = ecount + 1;
    endtask

    task automatic clear_logs();
        pulses.delete();
        falls.delete();
        first_held = -1;
    endtask

    initial begin
        int p, r, d;
        int exp_rep[6];
        rst = 1'b1;
        btn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pulse", pulse, 0);
        check("reset_level", lvl, 0);
        check("reset_held", hld, 0);
        rst = 1'b0;
        hold(0, 5);

        // clean press and release
        clear_logs();
        start(p);
        hold(1, 9);
        hold(0, 15);
        check("t1_pulse_count", pulses.size(), 1);
        check("t1_pulse_edge", pulses[0], p + 6);
        check("t1_fall_edge", falls[0], p + 16);
        check("t1_no_held", first_held, 32'hFFFF_FFFF);

        // press bounce
        clear_logs();
        hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 1);
        start(p);
        hold(1, 11);
        hold(0, 15);
        check("t2_pulse_count", pulses.size(), 1);
        check("t2_pulse_edge", pulses[0], p + 6);

        // release bounce
        clear_logs();
        start(p);
        hold(1, 11);
        hold(0, 2);
        hold(1, 3);
        hold(0, 20);
        check("t3_pulse_count", pulses.size(), 1);
        check("t3_fall_count", falls.size(), 1);
        check("t3_fall_edge", falls[0], p + 23);

        // reset while held
        clear_logs();
        start(p);
        hold(1, 9);
        @(negedge clk);
        rst = 1'b1;
        r = ecount + 1;
        @(negedge clk);
        check("t4_level_after_rst", lvl, 0);
        check("t4_pulse_after_rst", pulse, 0);
        check("t4_rst_edge", ecount, r);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        d = ecount + 1;
        hold(1, 13);
        hold(0, 15);
        check("t4_pulse_count", pulses.size(), 2);
        check("t4_first_pulse", pulses[0], p + 6);
        check("t4_second_pulse", pulses[1], d + 6);

        // long hold
        clear_logs();
        start(p);
        hold(1, 49);
        hold(0, 15);
`ifdef BUTTON_AUTO_REPEAT_EN
        exp_rep = '{6, 26, 32, 38, 44, 50};
        check("t5_pulse_count", pulses.size(), 6);
        for (int i = 0; i < 6; i++) check("t5_pulse_edge", pulses[i], p + exp_rep[i]);
        check("t5_held_edge", first_held, p + 26);
`else
        exp_rep = '{6, 0, 0, 0, 0, 0};
        check("t6_pulse_count", pulses.size(), 1);
        check("t6_pulse_edge", pulses[0], p + exp_rep[0]);
        check("t6_no_held", first_held, 32'hFFFF_FFFF);
`endif

        // random segments, occasional long holds and resets
        while (ecount < 5000) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                @(negedge clk);
                rst = 1'b1;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
            end else if (sel < 4) begin
                hold(1'($urandom_range(0, 1)), $urandom_range(20, 45));
            end else begin
                hold(1'($urandom_range(0, 1)), $urandom_range(1, 7));
            end
        end
        hold(0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
